iir_sample_tx: RTL
==================

IIR_SAMPLE_TX -- requirements
Module: iir_sample_tx

Interface
REQ-001 Parameter WL, default 28, sample word width, Q16.12 signed format.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer depth; power of two, at least 2.
REQ-003 Parameter CLK_DIV, default 4, clk cycles per serial bit; even, at least 2.
REQ-004 clk  input  1  single block clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sample_in  input  WL  signed filter output sample (y of the bandstop chain).
REQ-007 sample_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
REQ-008 clear_ovf  input  1  synchronous clear of overflow.
REQ-009 sclk  output  1  serial bit clock; idles low.
REQ-010 sdata  output  1  serial data, MSB first.
REQ-011 sync  output  1  high for the whole first (MSB) bit period of each frame.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 overflow  output  1  sticky flag; a sample was dropped.
REQ-014 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 The block SHALL write sample_in into the FIFO on any cycle with sample_valid=1 when the FIFO is not full.
REQ-016 The block SHALL discard sample_valid when the FIFO is full and no pop occurs in that cycle, and SHALL set overflow.
REQ-017 When a write and a pop occur in the same cycle, both SHALL take effect, including when full; fifo_level is then unchanged.
REQ-018 FSM states SHALL be IDLE, LOAD, SHIFT and GAP.
REQ-019 IDLE->LOAD when fifo_level>0. LOAD pops one word into a WL-bit shift register, clears the bit counter and goes to SHIFT after 1 cycle.
REQ-020 In SHIFT, each bit SHALL last exactly CLK_DIV cycles: sclk low for the first CLK_DIV/2 cycles, high for the second CLK_DIV/2; sdata changes only at bit start; receivers sample on the sclk rising edge.
REQ-021 SHIFT SHALL send WL bits, MSB first, then go to GAP.
REQ-022 GAP SHALL last CLK_DIV cycles with sclk=0, sdata=0, sync=0, then go to LOAD if fifo_level>0, else to IDLE.
REQ-023 Latency: with the FSM in IDLE and the FIFO empty, sample_valid in cycle N SHALL give LOAD in cycle N+1 and the first SHIFT cycle (MSB on sdata, sync=1) in cycle N+2.
REQ-024 Frame length SHALL be (WL+1)*CLK_DIV cycles including GAP, plus 1 LOAD cycle.
REQ-025 sample_in SHALL be transmitted bit-exact (two's complement), with no rounding or saturation.
REQ-026 overflow SHALL remain set until clear_ovf=1. If clear_ovf and a new drop occur in the same cycle, overflow SHALL stay 1.
REQ-027 sclk, sdata and sync SHALL be 0 in IDLE and LOAD.
REQ-028 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-029 reset_n=0 SHALL immediately set state=IDLE, fifo_level=0, overflow=0, sclk=0, sdata=0, sync=0, busy=0, and clear all pointers and counters.
REQ-030 Reset mid-frame SHALL abort the frame; buffered samples are lost; no partial frame resumes after release.
REQ-031 The first write SHALL be accepted on the first rising edge after reset_n is released.

Structure
REQ-032 FSM state encoding and the default WL/Q-format constants SHALL live in a shared package, iir_pkg.
REQ-033 The FIFO SHALL be a separate sub-module, iir_sample_fifo (write/pop/level/full/empty), instantiated once.

Verification
REQ-034 Send one sample 28'h0001000 (+1.0), CLK_DIV=4 -> sync=1 for cycles N+2..N+5; 28 bits 0000_0000_0000_0001_0000_0000_0000 on sclk rising edges; GAP; then IDLE.
REQ-035 Send 28'hFFFF000 (-1.0) -> received word equals 28'hFFFF000, with the first 16 bits all ones.
REQ-036 Send a burst of 6 back-to-back strobes from IDLE -> sample 1 popped in cycle 1; samples 2-5 buffered (fifo_level=4); sample 6 dropped; overflow=1; exactly 5 frames sent in order with one GAP between each.
REQ-037 With the FIFO full, apply a strobe in the same cycle as a LOAD pop -> the write is accepted, fifo_level stays 4, overflow stays 0.
REQ-038 Assert reset_n=0 at bit 10 of a frame -> outputs go to 0 immediately; after release, sdata stays 0 and busy=0 until a new strobe.
REQ-039 Assert clear_ovf while overflow=1 -> overflow=0 next cycle; clear_ovf coincident with a new drop -> overflow stays 1.

Source files
------------

// File: rtl/iir_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_pkg : shared sample-format constants and serialiser FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package iir_pkg;

    localparam int WL_DEFAULT  = 28;    // Q16.12 signed sample word
    localparam int Q_INT_BITS  = 16;
    localparam int Q_FRAC_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/iir_sample_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_sample_fifo : show-ahead sample buffer, extra pointer bit for full/empty
// Revision: 1.0
// ---------------------------------------------------------------------------
module iir_sample_fifo
    import iir_pkg::*;
#(
    parameter int WL    = WL_DEFAULT,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_i,
    input  logic [WL-1:0] wdata_i,
    input  logic          pop_i,
    output logic [WL-1:0] rdata_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [WL-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic          w_pop;
    logic          w_push;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees a slot, so a write into a full buffer still lands.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = wr_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (w_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/iir_sample_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_sample_tx : buffers filter samples and shifts them out MSB first
// Revision: 1.0
// ---------------------------------------------------------------------------
module iir_sample_tx
    import iir_pkg::*;
#(
    parameter int WL         = WL_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic signed [WL-1:0]          sample_in,
    input  logic                          sample_valid,
    input  logic                          clear_ovf,
    output logic                          sclk,
    output logic                          sdata,
    output logic                          sync,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BW   = $clog2(WL);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;

    tx_state_t     state_q, state_d;
    logic [WL-1:0] shreg_q, shreg_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [WL-1:0] fifo_rdata;
    logic          drop;

    iir_sample_fifo #(
        .WL    (WL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .wr_i    (sample_valid),
        .wdata_i (sample_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // When full the buffer is non-empty, so any LOAD pop frees a slot.
    assign drop = sample_valid && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        pop     = 1'b0;
        ovf_d   = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty || sample_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop     = 1'b1;
                shreg_d = fifo_rdata;
                bit_d   = '0;
                div_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (bit_q == BW'(WL - 1)) begin
                        state_d = ST_GAP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = {shreg_q[WL-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_GAP: begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    state_d = fifo_empty ? ST_IDLE : ST_LOAD;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

    // Serial outputs decode from registered state so reset clears them at once.
    assign sclk     = (state_q == ST_SHIFT) && (div_q >= DW'(HALF));
    assign sdata    = (state_q == ST_SHIFT) && shreg_q[WL-1];
    assign sync     = (state_q == ST_SHIFT) && (bit_q == '0);
    assign busy     = (state_q != ST_IDLE);
    assign overflow = ovf_q;

endmodule
`default_nettype wire
